// File: rtl/i2c_measure_sequencer.sv
// i2c_measure_sequencer
// Sweeps the enabled sensor channels. Each channel runs a write that triggers
// a conversion, a timed conversion wait and then a read, with a bounded retry
// when an engine times out. All outputs are registered from the current state,
// so they appear one cycle after the state they decode.
module i2c_measure_sequencer #(
  parameter int N_CH           = 4,
  parameter int CH_W           = 2,
  parameter int CONV_CYCLES    = 1000,
  parameter int CONV_W         = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16,
  parameter int TRIG_CYCLES    = 15,
  parameter int MAX_RETRY      = 2
) (
  input  logic            mclk,
  input  logic            resetG_n,
  input  logic            measure,
  input  logic            cont_mode,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            abort,
  input  logic            donew,
  input  logic            doner,
  output logic            StartW,
  output logic            StartR,
  output logic            sel,
  output logic [CH_W-1:0] ch_sel,
  output logic            exttrig,
  output logic            done,
  output logic            err,
  output logic [N_CH-1:0] err_flags,
  output logic            busy
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] SCAN   = 4'd1;
  localparam logic [3:0] WRITE  = 4'd2;
  localparam logic [3:0] WRITEB = 4'd3;
  localparam logic [3:0] CONV   = 4'd4;
  localparam logic [3:0] READ   = 4'd5;
  localparam logic [3:0] READB  = 4'd6;
  localparam logic [3:0] NEXT   = 4'd7;
  localparam logic [3:0] DONE   = 4'd8;

  // The scan pointer needs one extra bit so "past the last channel" is representable.
  localparam int PTR_W  = CH_W + 1;
  localparam int RT_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TRIG_W = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;

  localparam logic [CONV_W-1:0] CONV_LOAD = CONV_W'(CONV_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TRIG_W-1:0] TRIG_LOAD = TRIG_W'(TRIG_CYCLES - 1);
  localparam logic [RT_W-1:0]   RT_MAX    = RT_W'(MAX_RETRY);

  logic [3:0]        state_r;
  logic [3:0]        state_s;
  logic [PTR_W-1:0]  ptr_r;
  logic [N_CH-1:0]   mask_r;
  logic [RT_W-1:0]   retry_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [CONV_W-1:0] conv_cnt_r;
  logic [TRIG_W-1:0] trig_cnt_r;
  logic              abandon_r;
  logic              found_s;
  logic [CH_W-1:0]   found_idx_s;
  logic              to_hit_s;
  logic              retry_ok_s;
  logic              eng_done_s;

  assign to_hit_s   = (to_cnt_r == TO_LAST);
  assign retry_ok_s = (retry_r < RT_MAX);
  // Only the engine that belongs to the current wait state is listened to.
  assign eng_done_s = ((state_r == WRITEB) && donew) || ((state_r == READB) && doner);

  // Lowest enabled channel at or above the scan pointer (descending loop keeps the lowest).
  always_comb begin
    found_s     = 1'b0;
    found_idx_s = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_r[i] && (PTR_W'(i) >= ptr_r)) begin
        found_s     = 1'b1;
        found_idx_s = CH_W'(i);
      end else begin
        found_idx_s = found_idx_s;
      end
    end
  end

  // Next-state decision; abort overrides everything and measure is then ignored.
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:   if (measure) state_s = SCAN; else state_s = IDLE;
        SCAN:   if (found_s) state_s = WRITE; else state_s = DONE;
        WRITE:  state_s = WRITEB;
        WRITEB, READB: begin
          if (eng_done_s) begin
            if (state_r == WRITEB) state_s = CONV; else state_s = NEXT;
          end else if (to_hit_s) begin
            if (retry_ok_s) state_s = WRITE; else state_s = NEXT;
          end else begin
            state_s = state_r;
          end
        end
        CONV:   if (conv_cnt_r == '0) state_s = READ; else state_s = CONV;
        READ:   state_s = READB;
        NEXT:   state_s = SCAN;
        DONE:   if (cont_mode) state_s = SCAN; else state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register plus sweep bookkeeping: mask latch, pointer, counters, error flags.
  always_ff @(posedge mclk or negedge resetG_n) begin
    if (!resetG_n) begin
      state_r    <= IDLE;
      ptr_r      <= '0;
      mask_r     <= '0;
      retry_r    <= '0;
      to_cnt_r   <= '0;
      conv_cnt_r <= '0;
      abandon_r  <= 1'b0;
      ch_sel     <= '0;
      err_flags  <= '0;
    end else begin
      state_r <= state_s;
      if (!abort) begin
        case (state_r)
          IDLE: begin
            if (measure) begin
              mask_r    <= ch_mask;
              err_flags <= '0;
              ptr_r     <= '0;
            end
          end
          SCAN: begin
            abandon_r <= 1'b0;
            retry_r   <= '0;
            if (found_s) ch_sel <= found_idx_s;
          end
          WRITE, READ: to_cnt_r <= '0;
          WRITEB, READB: begin
            if (eng_done_s) begin
              conv_cnt_r <= CONV_LOAD;
            end else if (to_hit_s) begin
              if (retry_ok_s) begin
                retry_r <= retry_r + RT_W'(1);
              end else begin
                err_flags[ch_sel] <= 1'b1;
                abandon_r         <= 1'b1;
              end
            end else begin
              to_cnt_r <= to_cnt_r + TO_W'(1);
            end
          end
          CONV: if (conv_cnt_r != '0) conv_cnt_r <= conv_cnt_r - CONV_W'(1);
          NEXT: ptr_r <= PTR_W'(ch_sel) + PTR_W'(1);
          DONE: begin
            if (cont_mode) begin
              mask_r    <= ch_mask;
              err_flags <= '0;
              ptr_r     <= '0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Registered Moore outputs and the exttrig pulse stretcher (restarts on every READ).
  always_ff @(posedge mclk or negedge resetG_n) begin
    if (!resetG_n) begin
      StartW     <= 1'b0;
      StartR     <= 1'b0;
      sel        <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      exttrig    <= 1'b0;
      trig_cnt_r <= '0;
    end else if (abort) begin
      StartW     <= 1'b0;
      StartR     <= 1'b0;
      sel        <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      exttrig    <= 1'b0;
      trig_cnt_r <= '0;
    end else begin
      StartW <= (state_r == WRITE);
      StartR <= (state_r == READ);
      sel    <= (state_r == READ) || (state_r == READB);
      done   <= (state_r == DONE);
      err    <= (state_r == NEXT) && abandon_r;
      busy   <= (state_r != IDLE);
      if (state_r == READ) begin
        trig_cnt_r <= TRIG_LOAD;
        exttrig    <= 1'b1;
      end else if (trig_cnt_r != '0) begin
        trig_cnt_r <= trig_cnt_r - TRIG_W'(1);
        exttrig    <= 1'b1;
      end else begin
        exttrig    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_measure_sequencer.sv
// Testbench for i2c_measure_sequencer: directed scenarios plus randomized
// sweeps whose event timeline (write/read starts, errors, done) is predicted
// arithmetically from the per-attempt engine response plan.
module tb_i2c_measure_sequencer;

  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int CONV = 30;
  localparam int TO   = 8;
  localparam int TRIG = 15;
  localparam int MAXR = 2;
  localparam int NEVER = 1000;
  localparam int EV_W = 0, EV_R = 1, EV_E = 2, EV_D = 3;

  logic mclk, resetG_n, measure, cont_mode, abort, donew, doner;
  logic [N_CH-1:0] ch_mask, err_flags;
  logic StartW, StartR, sel, exttrig, done, err, busy;
  logic [CH_W-1:0] ch_sel;

  i2c_measure_sequencer #(
    .N_CH(N_CH), .CH_W(CH_W), .CONV_CYCLES(CONV), .CONV_W(16),
    .TIMEOUT_CYCLES(TO), .TO_W(16), .TRIG_CYCLES(TRIG), .MAX_RETRY(MAXR)
  ) dut (
    .mclk(mclk), .resetG_n(resetG_n), .measure(measure), .cont_mode(cont_mode),
    .ch_mask(ch_mask), .abort(abort), .donew(donew), .doner(doner),
    .StartW(StartW), .StartR(StartR), .sel(sel), .ch_sel(ch_sel),
    .exttrig(exttrig), .done(done), .err(err), .err_flags(err_flags), .busy(busy)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  typedef struct {
    int kind;
    int t;
    int ch;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int wd [N_CH][MAXR+1];
  int rd [N_CH][MAXR+1];
  int watt [N_CH];
  int w_at, r_at;
  bit both_mode, mon_on;
  int cyc, n_checks, n_errors, xbad, bbad, k_start, t_done;
  logic [N_CH-1:0] exp_flags;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic ev_t mk_ev(input int kind, input int t, input int ch);
    ev_t e;
    e.kind = kind;
    e.t    = t;
    e.ch   = ch;
    return e;
  endfunction

  function automatic bit exp_trig(input int c);
    foreach (exp_q[i])
      if (exp_q[i].kind == EV_R && c >= exp_q[i].t && c < exp_q[i].t + TRIG) return 1'b1;
    return 1'b0;
  endfunction

  // Reference timeline. Times are cycle indices at which an output is seen high.
  // A sweep sampled at edge k shows its first start (or done) at k+2. A write
  // answered after r cycles leads to StartR r+CONV+2 later; an answered read
  // leads to the next start r+4 later. An unanswered wait ends TO cycles after
  // its start pulse: a retry shows StartW one cycle later, giving up shows err
  // one cycle later and the next start two cycles after that.
  task automatic build_model(input logic [N_CH-1:0] m, input int k);
    int t, u, att;
    bit fin;
    exp_q.delete();
    exp_flags = '0;
    t = k + 2;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (m[ch]) begin
        att = 0;
        fin = 1'b0;
        while (!fin) begin
          exp_q.push_back(mk_ev(EV_W, t, ch));
          if (wd[ch][att] < TO) begin
            u = t + wd[ch][att] + CONV + 2;
            exp_q.push_back(mk_ev(EV_R, u, ch));
            if (rd[ch][att] < TO) begin
              t = u + rd[ch][att] + 4;
              fin = 1'b1;
            end else begin
              t = u + TO;
            end
          end else begin
            t = t + TO;
          end
          if (!fin) begin
            if (att < MAXR) begin
              att++;
              t = t + 1;
            end else begin
              exp_q.push_back(mk_ev(EV_E, t + 1, ch));
              exp_flags[ch] = 1'b1;
              t = t + 3;
              fin = 1'b1;
            end
          end
        end
      end
    end
    exp_q.push_back(mk_ev(EV_D, t, 0));
    t_done = t;
  endtask

  // One clock: sample outputs after the edge, log events, drive engine responses.
  task automatic step();
    int a;
    @(posedge mclk);
    #1;
    cyc++;
    if (StartW) begin
      obs_q.push_back(mk_ev(EV_W, cyc, int'(ch_sel)));
      a = (watt[ch_sel] > MAXR) ? MAXR : watt[ch_sel];
      w_at = (wd[ch_sel][a] < TO) ? cyc + wd[ch_sel][a] : -1;
      watt[ch_sel]++;
    end
    if (StartR) begin
      obs_q.push_back(mk_ev(EV_R, cyc, int'(ch_sel)));
      a = watt[ch_sel] - 1;
      if (a < 0) a = 0;
      if (a > MAXR) a = MAXR;
      r_at = (rd[ch_sel][a] < TO) ? cyc + rd[ch_sel][a] : -1;
    end
    if (err) obs_q.push_back(mk_ev(EV_E, cyc, int'(ch_sel)));
    if (done) begin
      obs_q.push_back(mk_ev(EV_D, cyc, 0));
      foreach (watt[i]) watt[i] = 0;
    end
    donew = (cyc == w_at);
    doner = (cyc == r_at) || (both_mode && cyc == w_at);
    if (mon_on) begin
      if (exttrig !== exp_trig(cyc)) xbad++;
      if (busy !== (cyc >= k_start + 1 && cyc <= t_done)) bbad++;
    end
  endtask

  task automatic fill_plan(input int wv, input int rv);
    for (int c = 0; c < N_CH; c++)
      for (int a = 0; a <= MAXR; a++) begin
        wd[c][a] = wv;
        rd[c][a] = rv;
      end
  endtask

  task automatic start_sweep(input logic [N_CH-1:0] m);
    w_at = -1;
    r_at = -1;
    foreach (watt[i]) watt[i] = 0;
    obs_q.delete();
    k_start = cyc + 1;
    ch_mask = m;
    measure = 1'b1;
    step();
    measure = 1'b0;
    ch_mask = N_CH'($urandom);
  endtask

  task automatic run_sweep(input string tag, input logic [N_CH-1:0] m, input bit both);
    int lim, last_r, n;
    both_mode = both;
    xbad = 0;
    bbad = 0;
    build_model(m, cyc + 1);
    last_r = cyc + 1;
    foreach (exp_q[i]) if (exp_q[i].kind == EV_R) last_r = exp_q[i].t;
    mon_on = 1'b1;
    start_sweep(m);
    lim = t_done + 2;
    if (last_r + TRIG + 1 > lim) lim = last_r + TRIG + 1;
    while (cyc < lim && cyc < k_start + 5000) step();
    mon_on = 1'b0;
    both_mode = 1'b0;
    check_val({tag, "_nevents"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_ev%0d_kind", tag, i), obs_q[i].kind, exp_q[i].kind);
      check_val($sformatf("%s_ev%0d_time", tag, i), obs_q[i].t - k_start, exp_q[i].t - k_start);
      check_val($sformatf("%s_ev%0d_ch", tag, i), obs_q[i].ch, exp_q[i].ch);
    end
    check_val({tag, "_err_flags"}, err_flags, exp_flags);
    check_val({tag, "_exttrig_bad_cycles"}, xbad, 0);
    check_val({tag, "_busy_bad_cycles"}, bbad, 0);
  endtask

  int n_r, n_e, n_w3, n_done, n_bad, t_w, t_r, d1, d2, uu;
  logic [N_CH-1:0] rm;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    w_at = -1; r_at = -1; both_mode = 1'b0; mon_on = 1'b0;
    measure = 1'b0; cont_mode = 1'b0; abort = 1'b0; donew = 1'b0; doner = 1'b0;
    ch_mask = '0;
    fill_plan(NEVER, NEVER);
    resetG_n = 1'b0;
    #1;
    check_val("reset_async_outputs", {StartW, StartR, sel, exttrig, done, err, busy}, 7'd0);
    repeat (2) @(posedge mclk);
    #3 resetG_n = 1'b1;
    step();
    check_val("reset_outputs", {StartW, StartR, sel, exttrig, done, err, busy}, 7'd0);
    check_val("reset_ch_sel", ch_sel, 0);
    check_val("reset_err_flags", err_flags, 0);

    // Two channels, every engine answers after 3 cycles.
    fill_plan(3, 3);
    run_sweep("basic", 4'b0101, 1'b0);
    t_w = -1; t_r = -1;
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == EV_W && t_w < 0) t_w = obs_q[i].t;
      if (obs_q[i].kind == EV_R && t_r < 0) t_r = obs_q[i].t;
    end
    check_val("basic_w_to_r_gap", t_r - t_w, 3 + CONV + 2);

    // Empty mask: straight to done.
    run_sweep("mask0", 4'b0000, 1'b0);
    check_val("mask0_done_latency", (obs_q.size() > 0) ? obs_q[0].t - k_start : -1, 2);

    // Channel 1 only, read engine never answers.
    fill_plan(2, NEVER);
    run_sweep("timeout", 4'b0010, 1'b0);
    n_r = 0; n_e = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i].kind == EV_R) n_r++;
      if (obs_q[i].kind == EV_E) n_e++;
    end
    check_val("timeout_read_starts", n_r, 1 + MAXR);
    check_val("timeout_err_pulses", n_e, 1);
    check_val("timeout_flags", err_flags, 4'b0010);

    // donew and doner together while waiting on the write engine.
    fill_plan(2, 2);
    run_sweep("both", 4'b0001, 1'b1);
    check_val("both_w_to_r_gap", (obs_q.size() > 1) ? obs_q[1].t - obs_q[0].t : -1, 2 + CONV + 2);

    // Continuous mode on channel 3; drop cont_mode after the second done.
    fill_plan(2, 2);
    cont_mode = 1'b1;
    start_sweep(4'b1000);
    n_done = 0; n_w3 = 0; n_bad = 0; d1 = 0; d2 = 0;
    for (int i = 0; i < 3 * (CONV + 12) + 60; i++) begin
      step();
      if (StartW) begin
        if (ch_sel == 2'd3) n_w3++; else n_bad++;
      end
      if (done) begin
        n_done++;
        if (n_done == 1) d1 = cyc;
        if (n_done == 2) begin
          d2 = cyc;
          cont_mode = 1'b0;
        end
      end
    end
    check_val("cont_done_count", n_done, 3);
    check_val("cont_writes_ch3", n_w3, 3);
    check_val("cont_writes_other", n_bad, 0);
    check_val("cont_sweep_period", d2 - d1, CONV + 12);
    check_val("cont_busy_after", busy, 1'b0);

    // Abort during the conversion wait of channel 1 after channel 0 failed.
    fill_plan(0, 3);
    for (int a = 0; a <= MAXR; a++) wd[0][a] = NEVER;
    start_sweep(4'b0011);
    t_w = -1;
    for (int i = 0; i < 500 && t_w < 0; i++) begin
      step();
      if (StartW && ch_sel == 2'd1) t_w = cyc;
    end
    check_val("abort_reached_ch1", (t_w > 0), 1'b1);
    repeat (5) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_val("abort_outputs", {StartW, StartR, sel, exttrig, done, err, busy}, 7'd0);
    check_val("abort_flags_held", err_flags, 4'b0001);
    n_r = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (StartR || done || busy) n_r++;
    end
    check_val("abort_no_activity", n_r, 0);
    // measure together with abort must be ignored.
    ch_mask = 4'b1111;
    measure = 1'b1;
    abort = 1'b1;
    step();
    measure = 1'b0;
    abort = 1'b0;
    repeat (2) step();
    check_val("abort_measure_busy", busy, 1'b0);
    check_val("abort_measure_flags", err_flags, 4'b0001);

    // Asynchronous reset in the read wait while exttrig is running.
    fill_plan(0, NEVER);
    for (int a = 0; a <= MAXR; a++) wd[0][a] = NEVER;
    start_sweep(4'b0011);
    uu = -1;
    for (int i = 0; i < 500 && uu < 0; i++) begin
      step();
      if (StartR && ch_sel == 2'd1) uu = cyc;
    end
    repeat (4) step();
    check_val("rst_pre_exttrig", exttrig, 1'b1);
    check_val("rst_pre_flags", err_flags, 4'b0001);
    #2 resetG_n = 1'b0;
    #1;
    check_val("rst_async_outputs", {StartW, StartR, sel, exttrig, done, err, busy}, 7'd0);
    check_val("rst_async_flags", err_flags, 4'b0000);
    w_at = -1; r_at = -1;
    step();
    resetG_n = 1'b1;
    step();
    check_val("rst_idle_busy", busy, 1'b0);
    repeat (20) step();

    // Randomized sweeps against the timeline model.
    for (int s = 0; s < 12; s++) begin
      for (int c = 0; c < N_CH; c++)
        for (int a = 0; a <= MAXR; a++) begin
          wd[c][a] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
          rd[c][a] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, TO - 1));
        end
      rm = N_CH'($urandom_range(0, 15));
      run_sweep($sformatf("rand%0d", s), rm, 1'($urandom_range(0, 1)));
      repeat (3) step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_measure_sequencer.md
Name: i2c_measure_sequencer

Overview:
- Parametrised successor to the single-channel I2C measurement control machine.
- Sequences measurement sweeps over up to N_CH sensor channels. Each channel runs: write (trigger conversion), internally timed conversion wait, read.
- Adds a per-channel enable mask, timeouts with bounded retry, per-channel error flags, continuous sweep mode, abort, and a parametrised external-trigger pulse.
- Sits between the application/Wishbone register block and the I2C read/write engines.

Parameters:
N_CH, 4, number of channels
CH_W, 2, channel index width (clog2(N_CH), min 1)
CONV_CYCLES, 1000, conversion wait in mclk cycles (>=1)
CONV_W, 16, conversion counter width
TIMEOUT_CYCLES, 50000, max cycles waiting for donew/doner (>=1)
TO_W, 16, timeout counter width
TRIG_CYCLES, 15, exttrig pulse length in cycles (>=1)
MAX_RETRY, 2, retries per channel after the first attempt

Ports:
mclk  in  1  system clock
resetG_n  in  1  asynchronous active-low reset
measure  in  1  start a sweep; sampled only in IDLE
cont_mode  in  1  1 = restart the sweep after DONE
ch_mask  in  N_CH  channel enables; sampled at sweep start
abort  in  1  synchronous abort, priority over all but reset
donew  in  1  write engine complete
doner  in  1  read engine complete
StartW  out  1  1-cycle write start pulse
StartR  out  1  1-cycle read start pulse
sel  out  1  high in READ/READB (read data path select)
ch_sel  out  CH_W  active channel index
exttrig  out  1  external trigger pulse
done  out  1  1-cycle sweep-complete pulse
err  out  1  1-cycle pulse when a channel is abandoned
err_flags  out  N_CH  per-channel failure bits for the current/last sweep
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (resetG_n low, asynchronous): state IDLE. All outputs 0; ch_sel=0, err_flags=0. Counters cleared and the latched mask cleared.
- All outputs are registered Moore outputs that reflect the current state.
- States: IDLE, SCAN, WRITE, WRITEB, CONV, READ, READB, NEXT, DONE.
- IDLE: when measure=1, latch ch_mask, clear err_flags, set ptr=0, go to SCAN.
- SCAN: find the lowest enabled channel with index >= ptr.
  - If found: load ch_sel, clear the retry counter, go to WRITE.
  - If none is left: go to DONE.
  - Mask 0 gives IDLE->SCAN->DONE, with done high and err_flags=0.
- WRITE: StartW=1 for 1 cycle; clear the timeout counter; go to WRITEB.
- WRITEB:
  - donew=1: go to CONV.
  - Otherwise, after TIMEOUT_CYCLES cycles in WRITEB, a timeout occurs.
- CONV: stay exactly CONV_CYCLES cycles (counter loaded CONV_CYCLES-1 on entry, exits on 0), then go to READ.
- READ: StartR=1, sel=1 for 1 cycle; exttrig starts; clear the timeout counter; go to READB.
- READB: sel=1.
  - doner=1: go to NEXT.
  - Otherwise, after TIMEOUT_CYCLES cycles, a timeout occurs.
- Timeout (in WRITEB or READB):
  - If retries < MAX_RETRY: increment retries, go to WRITE (a full restart of the channel).
  - Otherwise: set err_flags[ch_sel], pulse err for 1 cycle (in NEXT), go to NEXT.
- NEXT: ptr = ch_sel+1; go to SCAN. If ch_sel = N_CH-1, the next SCAN finds nothing and goes to DONE.
- DONE: done=1 for 1 cycle.
  - If cont_mode=1: re-latch ch_mask, clear err_flags, ptr=0, go to SCAN.
  - Otherwise: go to IDLE. err_flags hold until the next sweep start.
- donew is ignored outside WRITEB; doner is ignored outside READB; a simultaneous donew/doner acts only on the one relevant to the state.
- Done and timeout in the same cycle: done wins.
- exttrig: high for exactly TRIG_CYCLES cycles, starting the cycle the state is READ. Re-entry to READ while exttrig is active restarts the count. exttrig is independent of later state changes except abort and reset.
- abort=1 in any state:
  - Next cycle: IDLE; StartW/StartR/sel/exttrig/done/err=0.
  - err_flags are held.
  - No done pulse.
  - measure is ignored in a cycle where abort=1.
- Changes to ch_mask mid-sweep have no effect until the next sweep start.
- Latency: measure sampled at edge k gives StartW high after edge k+2 (IDLE->SCAN->WRITE).

Test Plan:
- Default params, ch_mask=4'b0101, measure pulse, donew/doner returned 3 cycles after each start -> StartW on ch_sel=0 then ch_sel=2. StartW->StartR gap = 3+CONV_CYCLES+2 cycles. exttrig high 15 cycles per read. One done pulse. err_flags=0. busy falls after DONE.
- ch_mask=0, measure -> done high exactly 2 cycles after sampling, no StartW/StartR, err_flags=0.
- Channel 1 only, doner never returned, TIMEOUT_CYCLES=8 -> 3 StartR pulses (1+MAX_RETRY), each preceded by StartW. err pulses once. err_flags=4'b0010. done follows.
- cont_mode=1, ch_mask=4'b1000 -> repeated sweeps on ch_sel=3 with done each sweep. Clearing cont_mode -> IDLE after the current DONE.
- abort asserted in CONV, then separately resetG_n pulsed low in READB mid-exttrig -> next cycle IDLE, all pulse outputs 0. Reset clears err_flags asynchronously, before any clock edge.
- Simultaneous donew=doner=1 in WRITEB -> goes to CONV only; doner pulse has no effect; exttrig not started until READ.
